// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU loader: FSM states, HALT opcode and default geometry.
// Optional parity storage is enabled with the TPU_LOADER_PARITY_EN macro.
package tpu_pkg;

  localparam int DEPTH = 16;
  localparam int DW    = 8;
  localparam int AW    = 4;

  localparam logic [2:0] HALT_OP = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/tpu_loader_if.sv
// Instruction stream handshake between the loader (master) and the compute consumer (slave).
interface tpu_loader_if #(
  parameter int DW = tpu_pkg::DW
);
  logic [DW-1:0] instr;
  logic          instr_valid;
  logic          instr_ready;

  modport master (output instr, output instr_valid, input instr_ready);
  modport slave  (input instr, input instr_valid, output instr_ready);
endinterface

// File: rtl/loader_mem.sv
// DEPTH x W register memory: synchronous write, cleared on reset, one registered read port
// that returns the pre-write contents when read and write hit the same address.
module loader_mem #(
  parameter int DEPTH = 16,
  parameter int W     = 8,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [W-1:0] rd_data_q, rd_data_d;

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[wr_addr] = wr_data;
    // Read from the current contents so a same-cycle write is not visible yet.
    rd_data_d = mem_q[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q     <= '{default: '0};
      rd_data_q <= '0;
    end else begin
      mem_q     <= mem_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/tpu_loader.sv
// TPU loader: DMA-fed weight/input/instruction memories and an IDLE/RUN/DONE instruction sequencer.
// Define TPU_LOADER_PARITY_EN to store an even-parity bit per entry and expose parity_err.
module tpu_loader #(
  parameter int DEPTH = tpu_pkg::DEPTH,
  parameter int DW    = tpu_pkg::DW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_w,
  input  logic                  fetch_inp,
  input  logic                  fetch_ins,
  input  logic                  start,
  input  logic [tpu_pkg::AW-1:0] dma_address,
  input  logic [DW-1:0]         data_in,
  input  logic [tpu_pkg::AW-1:0] w_rd_addr,
  input  logic [tpu_pkg::AW-1:0] inp_rd_addr,
  output logic [DW-1:0]         w_rd_data,
  output logic [DW-1:0]         inp_rd_data,
  tpu_loader_if.master          ins_if,
  output logic                  busy,
  output logic                  done,
  output logic                  wr_conflict
`ifdef TPU_LOADER_PARITY_EN
  ,
  output logic                  parity_err
`endif
);
  import tpu_pkg::AW;
  import tpu_pkg::HALT_OP;
  import tpu_pkg::IDLE;
  import tpu_pkg::RUN;
  import tpu_pkg::DONE;

  localparam logic [1:0] S_IDLE = 2'(IDLE);
  localparam logic [1:0] S_RUN  = 2'(RUN);
  localparam logic [1:0] S_DONE = 2'(DONE);

`ifdef TPU_LOADER_PARITY_EN
  localparam int MW = DW + 1;
  function automatic logic [MW-1:0] pack_word(input logic [DW-1:0] d);
    return {^d, d};
  endfunction
`else
  localparam int MW = DW;
  function automatic logic [MW-1:0] pack_word(input logic [DW-1:0] d);
    return d;
  endfunction
`endif

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          wr_conflict_q, wr_conflict_d;
  logic          we_w, we_inp, we_ins;
  logic          run, handshake, last_instr;
  logic [MW-1:0] wr_word, w_word, inp_word, ins_word;

  assign run     = (state_q == S_RUN);
  assign wr_word = pack_word(data_in);

  // One-hot write select; instruction writes are dropped while the sequencer owns the memory.
  assign we_w   = fetch_w;
  assign we_inp = fetch_inp & ~fetch_w;
  assign we_ins = fetch_ins & ~fetch_w & ~fetch_inp & ~run;

  assign handshake  = run & ins_if.instr_ready;
  assign last_instr = (ins_word[DW-1 -: 3] == HALT_OP) || (pc_q == AW'(DEPTH - 1));

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    wr_conflict_d = wr_conflict_q | (fetch_ins & run);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = '0;
        end
      end
      S_RUN: begin
        if (handshake) begin
          if (last_instr) state_d = S_DONE;
          else            pc_d    = pc_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  loader_mem #(.DEPTH(DEPTH), .W(MW), .AW(AW)) u_w_mem (
    .clk     (clk),
    .reset   (reset),
    .we      (we_w),
    .wr_addr (dma_address),
    .wr_data (wr_word),
    .rd_addr (w_rd_addr),
    .rd_data (w_word)
  );

  loader_mem #(.DEPTH(DEPTH), .W(MW), .AW(AW)) u_inp_mem (
    .clk     (clk),
    .reset   (reset),
    .we      (we_inp),
    .wr_addr (dma_address),
    .wr_data (wr_word),
    .rd_addr (inp_rd_addr),
    .rd_data (inp_word)
  );

  // Addressed by the next pc so the registered output already holds instr_mem[pc] in RUN.
  loader_mem #(.DEPTH(DEPTH), .W(MW), .AW(AW)) u_ins_mem (
    .clk     (clk),
    .reset   (reset),
    .we      (we_ins),
    .wr_addr (dma_address),
    .wr_data (wr_word),
    .rd_addr (pc_d),
    .rd_data (ins_word)
  );

  assign w_rd_data          = w_word[DW-1:0];
  assign inp_rd_data        = inp_word[DW-1:0];
  assign ins_if.instr       = run ? ins_word[DW-1:0] : '0;
  assign ins_if.instr_valid = run;
  assign busy               = run;
  assign done               = (state_q == S_DONE);
  assign wr_conflict        = wr_conflict_q;

`ifdef TPU_LOADER_PARITY_EN
  assign parity_err = (^w_word) | (^inp_word) | (run & (^ins_word));
`endif

endmodule

// File: tb/tb_tpu_loader.sv
// Directed-random bench for tpu_loader against a behavioural model of memories and program flow.
module tb_tpu_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       fetch_w, fetch_inp, fetch_ins, start;
  logic [3:0] dma_address, w_rd_addr, inp_rd_addr;
  logic [7:0] data_in, w_rd_data, inp_rd_data;
  logic       busy, done, wr_conflict;
`ifdef TPU_LOADER_PARITY_EN
  logic       parity_err;
`endif

  tpu_loader_if #(.DW(8)) ins_if ();

  tpu_loader dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_w     (fetch_w),
    .fetch_inp   (fetch_inp),
    .fetch_ins   (fetch_ins),
    .start       (start),
    .dma_address (dma_address),
    .data_in     (data_in),
    .w_rd_addr   (w_rd_addr),
    .inp_rd_addr (inp_rd_addr),
    .w_rd_data   (w_rd_data),
    .inp_rd_data (inp_rd_data),
    .ins_if      (ins_if.master),
    .busy        (busy),
    .done        (done),
    .wr_conflict (wr_conflict)
`ifdef TPU_LOADER_PARITY_EN
    ,
    .parity_err  (parity_err)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] wmem [16];
  logic [7:0] imem [16];
  logic [7:0] smem [16];
  logic       conflict_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      wmem[i] = 8'h00;
      imem[i] = 8'h00;
      smem[i] = 8'h00;
    end
    conflict_exp = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    model_clear();
  endtask

  // Write while idle; model applies weight > input > instruction priority.
  task automatic wr(input logic fw, input logic fi, input logic fs,
                    input logic [3:0] a, input logic [7:0] d);
    fetch_w = fw; fetch_inp = fi; fetch_ins = fs;
    dma_address = a; data_in = d;
    tick();
    fetch_w = 1'b0; fetch_inp = 1'b0; fetch_ins = 1'b0;
    if (fw)      wmem[a] = d;
    else if (fi) imem[a] = d;
    else if (fs) smem[a] = d;
  endtask

  task automatic rd_chk(input logic [3:0] aw, input logic [3:0] ai);
    logic [7:0] ew, ei;
    ew = wmem[aw];
    ei = imem[ai];
    w_rd_addr = aw;
    inp_rd_addr = ai;
    tick();
    chk($sformatf("w_rd[%0d]", aw), 32'(w_rd_data), 32'(ew));
    chk($sformatf("inp_rd[%0d]", ai), 32'(inp_rd_data), 32'(ei));
  endtask

  // mode 0: always ready, 1: random ready, 2: stall 4 cycles then ready.
  task automatic run_prog(input int mode, input bit inject, input string name);
    logic [7:0] exp_q [$];
    int idx, cyc;
    logic ready;
    logic [3:0] a;
    logic [7:0] d;
    bit fw;
    exp_q = {};
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(smem[i]);
      if (smem[i][7:5] == 3'b111) break;
    end
    start = 1'b1;
    tick();
    idx = 0;
    cyc = 0;
    while (1) begin
      if (cyc >= 300) begin
        chk({name, "_timeout"}, 32'(idx), 32'(exp_q.size()));
        break;
      end
      if (mode == 0)      ready = 1'b1;
      else if (mode == 2) ready = (cyc >= 4);
      else                ready = 1'($urandom % 2);
      ins_if.instr_ready = ready;
      start = 1'($urandom % 2);
      chk({name, "_valid"}, 32'(ins_if.instr_valid), 32'd1);
      chk({name, "_instr"}, 32'(ins_if.instr), 32'(exp_q[idx]));
      chk({name, "_busy"}, 32'(busy), 32'd1);
      chk({name, "_done"}, 32'(done), 32'd0);
      chk({name, "_conflict"}, 32'(wr_conflict), 32'(conflict_exp));
`ifdef TPU_LOADER_PARITY_EN
      chk({name, "_parity"}, 32'(parity_err), 32'd0);
`endif
      fw = 1'($urandom % 2);
      a = 4'($urandom);
      d = 8'($urandom);
      if (inject && cyc == 1) begin
        fw = 1'b0;
        fetch_ins = 1'b1;
        a = 4'd1;
        d = 8'h55;
      end
      fetch_w = fw;
      dma_address = a;
      data_in = d;
      tick();
      if (fw) wmem[a] = d;
      if (fetch_ins) conflict_exp = 1'b1;
      fetch_w = 1'b0;
      fetch_ins = 1'b0;
      cyc++;
      if (ready) begin
        idx++;
        if (idx == exp_q.size()) break;
      end
    end
    start = 1'b0;
    ins_if.instr_ready = 1'b0;
    chk({name, "_done_pulse"}, 32'(done), 32'd1);
    chk({name, "_done_busy"}, 32'(busy), 32'd0);
    chk({name, "_done_valid"}, 32'(ins_if.instr_valid), 32'd0);
    chk({name, "_done_instr"}, 32'(ins_if.instr), 32'd0);
    tick();
    chk({name, "_idle_done"}, 32'(done), 32'd0);
    chk({name, "_idle_valid"}, 32'(ins_if.instr_valid), 32'd0);
    chk({name, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] old_v, new_v, b;
    int h;
    reset = 1'b1;
    fetch_w = 1'b0; fetch_inp = 1'b0; fetch_ins = 1'b0; start = 1'b0;
    dma_address = '0; data_in = '0; w_rd_addr = '0; inp_rd_addr = '0;
    ins_if.instr_ready = 1'b0;
    do_reset();

    // Reset state
    chk("rst_w_rd", 32'(w_rd_data), 32'd0);
    chk("rst_inp_rd", 32'(inp_rd_data), 32'd0);
    chk("rst_instr", 32'(ins_if.instr), 32'd0);
    chk("rst_valid", 32'(ins_if.instr_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_conflict", 32'(wr_conflict), 32'd0);

    // Weight write lands only in weight memory
    wr(1'b1, 1'b0, 1'b0, 4'd3, 8'hA5);
    rd_chk(4'd3, 4'd3);

    // Strobe priority
    wr(1'b1, 1'b1, 1'b1, 4'd5, 8'h3C);
    rd_chk(4'd5, 4'd5);
    wr(1'b0, 1'b1, 1'b1, 4'd6, 8'h4D);
    rd_chk(4'd6, 4'd6);

    // Random fills of weight and input memories
    for (int i = 0; i < 8; i++) begin
      wr(1'b1, 1'b0, 1'b0, 4'($urandom), 8'($urandom));
      wr(1'b0, 1'b1, 1'b0, 4'($urandom), 8'($urandom));
    end
    for (int i = 0; i < 16; i++) rd_chk(4'(i), 4'(15 - i));

    // Read and write to the same address in one cycle returns old data
    old_v = wmem[7];
    new_v = ~old_v;
    w_rd_addr = 4'd7;
    fetch_w = 1'b1; dma_address = 4'd7; data_in = new_v;
    tick();
    fetch_w = 1'b0;
    chk("rdw_old", 32'(w_rd_data), 32'(old_v));
    wmem[7] = new_v;
    tick();
    chk("rdw_new", 32'(w_rd_data), 32'(new_v));

    // Three-instruction program ending in HALT
    wr(1'b0, 1'b0, 1'b1, 4'd0, 8'h11);
    wr(1'b0, 1'b0, 1'b1, 4'd1, 8'h22);
    wr(1'b0, 1'b0, 1'b1, 4'd2, 8'hE0);
    run_prog(0, 1'b0, "halt3");

    // Stall 4 cycles, with a dropped instruction write during RUN
    run_prog(2, 1'b1, "stall");
    chk("conflict_sticky", 32'(wr_conflict), 32'd1);

    // Random program with random consumer backpressure
    h = $urandom_range(3, 12);
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom_range(0, 223));
      if (i == h) b = 8'hE0 | 8'($urandom % 32);
      wr(1'b0, 1'b0, 1'b1, 4'(i), b);
    end
    run_prog(1, 1'b0, "rand");

    // Full memory of non-HALT instructions stops after the last entry
    for (int i = 0; i < 16; i++) wr(1'b0, 1'b0, 1'b1, 4'(i), 8'h01);
    run_prog(0, 1'b0, "full16");
    for (int i = 0; i < 16; i++) rd_chk(4'(i), 4'(i));

    // Reset in the middle of RUN aborts without done and clears memories
    start = 1'b1;
    ins_if.instr_ready = 1'b0;
    tick();
    start = 1'b0;
    chk("abort_busy_pre", 32'(busy), 32'd1);
    ins_if.instr_ready = 1'b1;
    tick();
    reset = 1'b1;
    start = 1'b1;
    fetch_w = 1'b1; dma_address = 4'd2; data_in = 8'h77;
    tick();
    reset = 1'b0;
    start = 1'b0;
    fetch_w = 1'b0;
    ins_if.instr_ready = 1'b0;
    model_clear();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_valid", 32'(ins_if.instr_valid), 32'd0);
    chk("abort_conflict", 32'(wr_conflict), 32'd0);
    tick();
    chk("abort_no_done", 32'(done), 32'd0);
    chk("abort_idle_busy", 32'(busy), 32'd0);
    rd_chk(4'd2, 4'd3);
    rd_chk(4'd3, 4'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tpu_loader.md
TPU_LOADER -- requirements
Module: tpu_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 16: entries per memory (weights, inputs, instructions).
REQ-002 SHALL have parameter DW, default 8: data/instruction width in bits.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port fetch_w, input, 1: write data_in to weight memory at dma_address.
REQ-006 SHALL have port fetch_inp, input, 1: write data_in to input memory at dma_address.
REQ-007 SHALL have port fetch_ins, input, 1: write data_in to instruction memory at dma_address.
REQ-008 SHALL have port start, input, 1: begin instruction sequencing.
REQ-009 SHALL have port dma_address, input, 4: write address.
REQ-010 SHALL have port data_in, input, DW: write data byte.
REQ-011 SHALL have ports w_rd_addr and inp_rd_addr, input, 4: compute-side read addresses.
REQ-012 SHALL have ports w_rd_data and inp_rd_data, output, DW: registered read data.
REQ-013 SHALL have port instr, output, DW: current instruction.
REQ-014 SHALL have port instr_valid, output, 1: instr is valid.
REQ-015 SHALL have port instr_ready, input, 1: consumer accepts instr.
REQ-016 SHALL have ports busy, output, 1 (state RUN), and done, output, 1 (one-cycle completion pulse).
REQ-017 SHALL have port wr_conflict, output, 1: sticky flag for an instruction write during RUN.

Function
REQ-018 Writes SHALL take effect at the clock edge where the strobe is high. Simultaneous strobes use priority fetch_w > fetch_inp > fetch_ins, and only one memory is written.
REQ-019 Read ports SHALL have 1-cycle latency. A read and write to the same address in the same cycle SHALL return the old data.
REQ-020 FSM states SHALL be IDLE, RUN, DONE.
REQ-021 IDLE->RUN when start=1: pc<=0, busy=1 from the next cycle. start SHALL be ignored in RUN and DONE.
REQ-022 In RUN: instr = instr_mem[pc] and instr_valid=1. instr SHALL hold stable while instr_valid && !instr_ready.
REQ-023 A handshake occurs when instr_valid && instr_ready; on a handshake pc SHALL increment by 1.
REQ-024 RUN->DONE on a handshake of an instruction with instr[7:5]==HALT_OP (3'b111), or on a handshake at pc==DEPTH-1 (no wrap). The HALT instruction SHALL itself be presented and accepted.
REQ-025 DONE SHALL last exactly 1 cycle with done=1, busy=0, instr_valid=0, then return to IDLE.
REQ-026 fetch_ins during RUN SHALL be dropped and SHALL set wr_conflict. Weight and input writes SHALL remain permitted in every state.
REQ-027 instr_valid SHALL be 0 in IDLE and DONE, and instr SHALL be 0 when instr_valid=0.

Reset
REQ-028 On reset: state=IDLE, pc=0, all three memories cleared to 0, w_rd_data=inp_rd_data=0, instr=0, instr_valid=busy=done=wr_conflict=0.
REQ-029 Reset asserted mid-RUN SHALL abort to IDLE on the next edge without emitting done. Reset SHALL override any concurrent start or write.

Configuration
REQ-030 Macro TPU_LOADER_PARITY_EN: when defined, each entry SHALL store an even-parity bit, and output parity_err (1 bit) SHALL pulse 1 cycle on any read or instruction presentation whose parity mismatches.
REQ-031 Without TPU_LOADER_PARITY_EN: no parity storage and no parity_err port.

Structure
REQ-032 Package tpu_pkg SHALL hold the state enum (IDLE/RUN/DONE), HALT_OP, DEPTH, DW and the address width.
REQ-033 Sub-module loader_mem (DEPTH x DW, sync write, sync-clear on reset, one registered read port) SHALL be instantiated three times.

Verification
REQ-034 fetch_w, addr 3, data 0xA5; next cycle w_rd_addr=3 -> w_rd_data=0xA5 one cycle later; inp memory unaffected (reads 0).
REQ-035 Load ins[0..2]=0x11,0x22,0xE0; start; instr_ready=1 -> instr 0x11,0x22,0xE0 on consecutive cycles, then done=1 for one cycle, busy=0.
REQ-036 In RUN hold instr_ready=0 for 4 cycles -> instr stays 0x11, pc unchanged; instr_ready=1 -> advances to 0x22.
REQ-037 All 16 instructions 0x01, instr_ready=1 -> 16 handshakes, DONE after pc=15, no wrap to 0.
REQ-038 fetch_ins addr 1 data 0x55 during RUN -> wr_conflict=1 (sticky), ins[1] unchanged; reset mid-RUN -> IDLE, no done, memories read 0.
